// File: rtl/utils_pkg.sv
// Shared register-file types and writeback-path definitions.
package utils_pkg;

  localparam int unsigned RF_XLEN = 32;

  typedef logic [4:0]         raddr_t;
  typedef logic [RF_XLEN-1:0] rdata_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LSU_FIFO,
    WB_LSU_BYP
  } wb_src_t;

  typedef struct packed {
    raddr_t addr;
    rdata_t data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; head is visible combinationally.
module wb_fifo
  import utils_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  wb_req_t                      i_data,
  input  logic                         i_pop,
  output wb_req_t                      o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  wb_req_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and load results onto the register-file write port and tracks
// pending load destinations for decode hazard checks.
module rf_writeback_arbiter
  import utils_pkg::*;
#(
  parameter int unsigned LSU_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_rd_addr_i,
  input  logic [XLEN-1:0] alu_rd_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_addr_i,
  input  logic [XLEN-1:0] lsu_rd_data_i,
  input  logic            lock_i,
  input  logic [4:0]      lock_addr_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic            we_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT+1);
  localparam int unsigned CW = $clog2(LSU_FIFO_DEPTH+1);

  logic            r_we;
  raddr_t          r_rd_addr;
  logic [XLEN-1:0] r_rd_data;
  logic [SW-1:0]   r_starve;
  logic [31:0]     r_pending;

  wb_req_t         w_alu_req;
  wb_req_t         w_lsu_req;
  wb_req_t         w_head;
  wb_req_t         w_win;
  wb_src_t         w_src;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;
  logic            w_alu_win;
  logic            w_push;
  logic            w_pop;
  logic            w_load_wr;
  logic [SW-1:0]   w_starve_nxt;
  logic [31:0]     w_pend_nxt;

  assign w_alu_req = '{addr: alu_rd_addr_i, data: rdata_t'(alu_rd_data_i)};
  assign w_lsu_req = '{addr: lsu_rd_addr_i, data: rdata_t'(lsu_rd_data_i)};

  assign alu_ready_o = (r_starve != SW'(STARVE_LIMIT));
  assign lsu_ready_o = !w_fifo_full;
  assign w_alu_win   = alu_valid_i && alu_ready_o;

  always_comb begin
    w_src = WB_NONE;
    w_win = '0;
    if (w_alu_win) begin
      w_src = WB_ALU;
      w_win = w_alu_req;
    end else if (!w_fifo_empty) begin
      w_src = WB_LSU_FIFO;
      w_win = w_head;
    end else if (lsu_valid_i) begin
      w_src = WB_LSU_BYP;
      w_win = w_lsu_req;
    end
  end

  assign w_pop     = (w_src == WB_LSU_FIFO);
  assign w_push    = lsu_valid_i && lsu_ready_o && (w_src != WB_LSU_BYP);
  assign w_load_wr = (w_src == WB_LSU_FIFO) || (w_src == WB_LSU_BYP);

  // Non-empty FIFO means either the ALU won or the head was popped.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || (w_fifo_count == '0)) w_starve_nxt = '0;
    else if (w_src == WB_ALU)          w_starve_nxt = r_starve + SW'(1);
  end

  // Set is applied after clear so a same-cycle relock keeps the bit pending.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_load_wr && (w_win.addr != '0)) w_pend_nxt[w_win.addr] = 1'b0;
    if (lock_i && (lock_addr_i != '0))  w_pend_nxt[lock_addr_i] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we      <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_starve  <= '0;
      r_pending <= '0;
    end else begin
      r_we <= (w_src != WB_NONE) && (w_win.addr != '0);
      if (w_src != WB_NONE) begin
        r_rd_addr <= w_win.addr;
        r_rd_data <= XLEN'(w_win.data);
      end
      r_starve  <= w_starve_nxt;
      r_pending <= w_pend_nxt;
    end
  end

  assign rs1_busy_o = r_pending[rs1_addr_i];
  assign rs2_busy_o = r_pending[rs2_addr_i];
  assign we_o       = r_we;
  assign rd_addr_o  = r_rd_addr;
  assign rd_data_o  = r_rd_data;

  wb_fifo #(
    .DEPTH(LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_data  (w_lsu_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench: directed table, multi-cycle sequences, random vs. queue model.
module tb_rf_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid_i, alu_ready_o;
  logic [4:0]  alu_rd_addr_i;
  logic [31:0] alu_rd_data_i;
  logic        lsu_valid_i, lsu_ready_o;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_rd_data_i;
  logic        lock_i;
  logic [4:0]  lock_addr_i, rs1_addr_i, rs2_addr_i;
  logic        rs1_busy_o, rs2_busy_o, we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  rf_writeback_arbiter #(
    .LSU_FIFO_DEPTH(DEPTH),
    .STARVE_LIMIT  (LIMIT),
    .XLEN          (32)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_addr_i(alu_rd_addr_i), .alu_rd_data_i(alu_rd_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_rd_data_i(lsu_rd_data_i),
    .lock_i(lock_i), .lock_addr_i(lock_addr_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .we_o(we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [4:0] a; logic [31:0] d; } ld_t;
  ld_t         q[$];
  int          cnt;
  logic [31:0] pend;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic lk; logic [4:0] lka; logic [4:0] r1;
    logic ear; logic elr; logic eb1; logic ewe; logic [4:0] ea; logic [31:0] ed;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cnt = 0; pend = '0; m_we = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_check();
    chk("alu_ready", 32'(alu_ready_o), 32'(cnt != LIMIT));
    chk("lsu_ready", 32'(lsu_ready_o), 32'(q.size() < DEPTH));
    chk("rs1_busy",  32'(rs1_busy_o),  32'(rs1_addr_i != 0 && pend[rs1_addr_i]));
    chk("rs2_busy",  32'(rs2_busy_o),  32'(rs2_addr_i != 0 && pend[rs2_addr_i]));
    chk("we",        32'(we_o),        32'(m_we));
    chk("rd_addr",   32'(rd_addr_o),   32'(m_addr));
    chk("rd_data",   rd_data_o,        m_data);
  endtask

  task automatic model_advance();
    bit alu_take, lsu_take, wrote, is_load, bypass;
    logic [4:0]  wa;
    logic [31:0] wd;
    ld_t h;
    int qn;
    qn = q.size();
    alu_take = alu_valid_i && (cnt != LIMIT);
    lsu_take = lsu_valid_i && (qn < DEPTH);
    wrote = 0; is_load = 0; bypass = 0; wa = '0; wd = '0;
    if (alu_take) begin
      wrote = 1; wa = alu_rd_addr_i; wd = alu_rd_data_i;
    end else if (qn > 0) begin
      h = q.pop_front();
      wrote = 1; is_load = 1; wa = h.a; wd = h.d;
    end else if (lsu_take) begin
      wrote = 1; is_load = 1; bypass = 1; wa = lsu_rd_addr_i; wd = lsu_rd_data_i;
    end
    if (lsu_take && !bypass) q.push_back('{a: lsu_rd_addr_i, d: lsu_rd_data_i});
    cnt = (qn == 0 || is_load) ? 0 : cnt + 1;
    if (is_load && wa != 0) pend[wa] = 1'b0;
    if (lock_i && lock_addr_i != 0) pend[lock_addr_i] = 1'b1;
    m_we = wrote && (wa != 0);
    if (wrote) begin m_addr = wa; m_data = wd; end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alu_valid_i = 0; alu_rd_addr_i = '0; alu_rd_data_i = '0;
    lsu_valid_i = 0; lsu_rd_addr_i = '0; lsu_rd_data_i = '0;
    lock_i = 0; lock_addr_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
  endtask

  initial begin
    tbl[0]  = '{1,5,32'hDEADBEEF, 0,0,0,      0,0,0, 1,1,0,0,0,0};
    tbl[1]  = '{0,0,0,            0,0,0,      1,7,7, 1,1,0,1,5,32'hDEADBEEF};
    tbl[2]  = '{0,0,0,            0,0,0,      0,0,7, 1,1,1,0,0,0};
    tbl[3]  = '{0,0,0,            1,7,32'h1234, 0,0,7, 1,1,1,0,0,0};
    tbl[4]  = '{0,0,0,            0,0,0,      0,0,7, 1,1,0,1,7,32'h1234};
    tbl[5]  = '{1,3,32'h33,       1,4,32'h44, 0,0,0, 1,1,0,0,0,0};
    tbl[6]  = '{0,0,0,            0,0,0,      0,0,0, 1,1,0,1,3,32'h33};
    tbl[7]  = '{0,0,0,            0,0,0,      0,0,0, 1,1,0,1,4,32'h44};
    tbl[8]  = '{1,0,32'hFFFF,     0,0,0,      1,0,0, 1,1,0,0,0,0};
    tbl[9]  = '{0,0,0,            0,0,0,      0,0,0, 1,1,0,0,0,0};
    tbl[10] = '{0,0,0,            0,0,0,      0,0,0, 1,1,0,0,0,0};

    set_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we",        32'(we_o),        32'd0);
    chk("reset_rd_addr",   32'(rd_addr_o),   32'd0);
    chk("reset_rd_data",   rd_data_o,        32'd0);
    chk("reset_lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("reset_alu_ready", 32'(alu_ready_o), 32'd1);
    model_reset();
    rst = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 11; i++) begin
      alu_valid_i = tbl[i].av; alu_rd_addr_i = tbl[i].aa; alu_rd_data_i = tbl[i].ad;
      lsu_valid_i = tbl[i].lv; lsu_rd_addr_i = tbl[i].la; lsu_rd_data_i = tbl[i].ld;
      lock_i = tbl[i].lk; lock_addr_i = tbl[i].lka; rs1_addr_i = tbl[i].r1; rs2_addr_i = '0;
      #2;
      chk($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready_o), 32'(tbl[i].ear));
      chk($sformatf("tbl%0d_lsu_ready", i), 32'(lsu_ready_o), 32'(tbl[i].elr));
      chk($sformatf("tbl%0d_rs1_busy", i),  32'(rs1_busy_o),  32'(tbl[i].eb1));
      chk($sformatf("tbl%0d_we", i),        32'(we_o),        32'(tbl[i].ewe));
      if (tbl[i].ewe) begin
        chk($sformatf("tbl%0d_rd_addr", i), 32'(rd_addr_o), 32'(tbl[i].ea));
        chk($sformatf("tbl%0d_rd_data", i), rd_data_o,       tbl[i].ed);
      end
      tick();
    end

    // Starvation: two loads queue behind a continuous ALU stream
    for (int i = 0; i < 12; i++) begin
      set_idle();
      alu_valid_i = 1; alu_rd_addr_i = 5'(10 + i % 5); alu_rd_data_i = 32'(i + 100);
      if (i == 0) begin lsu_valid_i = 1; lsu_rd_addr_i = 8; lsu_rd_data_i = 32'h88; end
      if (i == 1) begin lsu_valid_i = 1; lsu_rd_addr_i = 9; lsu_rd_data_i = 32'h99; end
      #2;
      if (i == 2)  chk("starve_fifo_full", 32'(lsu_ready_o), 32'd0);
      if (i == 4)  chk("starve_alu_ok",    32'(alu_ready_o), 32'd1);
      if (i == 5)  chk("starve_stall_x8",  32'(alu_ready_o), 32'd0);
      if (i == 6)  chk("starve_write_x8",  32'(rd_addr_o),   32'd8);
      if (i == 9)  chk("starve_alu_ok2",   32'(alu_ready_o), 32'd1);
      if (i == 10) chk("starve_stall_x9",  32'(alu_ready_o), 32'd0);
      if (i == 11) chk("starve_write_x9",  32'(rd_addr_o),   32'd9);
      tick();
    end
    set_idle();
    repeat (3) tick();

    // Reset while two loads are buffered and their destinations are pending
    set_idle(); lock_i = 1; lock_addr_i = 20; tick();
    set_idle(); lock_i = 1; lock_addr_i = 21; tick();
    set_idle(); alu_valid_i = 1; alu_rd_addr_i = 1;
    lsu_valid_i = 1; lsu_rd_addr_i = 20; lsu_rd_data_i = 32'h2020; tick();
    lsu_rd_addr_i = 21; lsu_rd_data_i = 32'h2121; tick();
    set_idle(); alu_valid_i = 1; alu_rd_addr_i = 2; rs1_addr_i = 20; rs2_addr_i = 21;
    #1;
    chk("prerst_lsu_full", 32'(lsu_ready_o), 32'd0);
    chk("prerst_rs1_busy", 32'(rs1_busy_o),  32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_we",        32'(we_o),        32'd0);
    chk("midrst_lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("midrst_rs1_busy",  32'(rs1_busy_o),  32'd0);
    chk("midrst_rs2_busy",  32'(rs2_busy_o),  32'd0);
    model_reset();
    set_idle(); rs1_addr_i = 20; rs2_addr_i = 21;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) tick();

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      alu_valid_i   = ($urandom_range(0, 99) < 55);
      alu_rd_addr_i = 5'($urandom_range(0, 7));
      alu_rd_data_i = $urandom;
      lsu_valid_i   = ($urandom_range(0, 99) < 50);
      lsu_rd_addr_i = 5'($urandom_range(0, 7));
      lsu_rd_data_i = $urandom;
      lock_i        = ($urandom_range(0, 3) == 0);
      lock_addr_i   = 5'($urandom_range(0, 7));
      rs1_addr_i    = 5'($urandom_range(0, 7));
      rs2_addr_i    = 5'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
